uart_tx_fifo: RTL and testbench

Byte FIFO and send sequencer placed directly upstream of `uart_tx`. It accepts bytes from the system side at up to one per clock and stores them in a circular buffer. It presents them one at a time on the `uart_tx` valid/byte inputs, holding each byte until `uart_tx` pulses done. This decouples bursty producers from the serial line rate.

---
 rtl/uart_tx_fifo.sv | 64 ++++++
 tb/tb_uart_tx_fifo.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that feeds uart_tx one byte at a time, holding each until done
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_SysClock,
  input  logic                  i_ResetN,
  input  logic                  i_WrValid,
  input  logic [7:0]            i_WrByte,
  output logic                  o_WrReady,
  output logic                  o_Overflow,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic                  o_Empty,
  output logic                  o_Full,
  output logic                  o_TxValid,
  output logic [7:0]            o_TxByte,
  input  logic                  i_TxDone
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  wr, pop;
  assign o_Count   = count;
  assign o_Empty   = count == '0;
  assign o_Full    = count == (DEPTH_LOG2+1)'(DEPTH);
  assign o_WrReady = !o_Full;
  assign wr        = i_WrValid & o_WrReady;
  assign pop       = (state == S_SEND) & i_TxDone;
  always_ff @(posedge i_SysClock)
    if (i_ResetN && wr) mem[wr_ptr] <= i_WrByte;
  always_ff @(posedge i_SysClock) begin
    if (!i_ResetN) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_TxValid  <= 1'b0;
      o_TxByte   <= 8'h00;
      o_Overflow <= 1'b0;
    end else begin
      o_Overflow <= i_WrValid & o_Full;
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (DEPTH_LOG2+1)'(wr) - (DEPTH_LOG2+1)'(pop);
      case (state)
        S_IDLE: if (count != '0) begin
          o_TxByte  <= mem[rd_ptr];
          o_TxValid <= 1'b1;
          state     <= S_SEND;
        end
        S_SEND: if (i_TxDone) begin
          o_TxValid <= 1'b0;
          state     <= S_GAP;
        end
        default: begin
          o_TxValid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of FIFO storage, overflow, sequencing and gap timing
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst_n, wr_valid, tx_done;
  logic [7:0] wr_byte;
  logic       wr_ready, overflow, empty, full, tx_valid;
  logic [4:0] count;
  logic [7:0] tx_byte;
  int         errors = 0;
  int         checks = 0;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .i_SysClock(clk), .i_ResetN(rst_n), .i_WrValid(wr_valid), .i_WrByte(wr_byte),
    .o_WrReady(wr_ready), .o_Overflow(overflow), .o_Count(count), .o_Empty(empty),
    .o_Full(full), .o_TxValid(tx_valid), .o_TxByte(tx_byte), .i_TxDone(tx_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write1(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_byte  = b;
    tick();
    wr_valid = 1'b0;
  endtask

  // waits (bounded) for a presented byte, returns it, then acknowledges with a one-cycle done
  task automatic get_byte(output logic [7:0] b, output logic ok);
    for (int i = 0; i < 20 && !tx_valid; i++) tick();
    ok = tx_valid;
    b  = tx_byte;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr_valid = 1'b0; wr_byte = 8'h00; tx_done = 1'b0;
    tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_txvalid got=%b want=0", tx_valid); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_txbyte got=%h want=00", tx_byte); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if ({wr_ready, empty, full} !== 3'b110) begin errors++; $display("FAIL reset_flags got=%b want=110", {wr_ready, empty, full}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    write1(8'hA5);
    checks++; if (count !== 5'd1 || tx_valid !== 1'b0) begin errors++; $display("FAIL single_edge_n count=%0d valid=%b want 1/0", count, tx_valid); end
    tick();
    checks++; if (tx_valid !== 1'b1 || tx_byte !== 8'hA5) begin errors++; $display("FAIL single_present valid=%b byte=%h want 1/a5", tx_valid, tx_byte); end
    tick(); tick();
    checks++; if (tx_valid !== 1'b1 || tx_byte !== 8'hA5 || count !== 5'd1) begin errors++; $display("FAIL single_hold valid=%b byte=%h count=%0d", tx_valid, tx_byte, count); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++; if (tx_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_pop valid=%b count=%0d empty=%b want 0/0/1", tx_valid, count, empty); end
    tick(); tick(); tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_idle valid=%b want=0", tx_valid); end
  endtask

  task automatic test_burst;
    logic [7:0] b;
    logic       ok;
    wr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_byte = 8'(i);
      tick();
    end
    checks++; if (full !== 1'b1 || wr_ready !== 1'b0 || count !== 5'd16) begin errors++; $display("FAIL burst_full full=%b ready=%b count=%0d want 1/0/16", full, wr_ready, count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL burst_no_ovf got=%b want=0", overflow); end
    wr_byte = 8'hEE;
    tick();
    wr_valid = 1'b0;
    checks++; if (overflow !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL burst_ovf ovf=%b count=%0d want 1/16", overflow, count); end
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL burst_ovf_pulse got=%b want=0", overflow); end
    for (int i = 0; i < 16; i++) begin
      get_byte(b, ok);
      checks++; if (!ok || b !== 8'(i)) begin errors++; $display("FAIL burst_order[%0d] ok=%b got=%h want=%h", i, ok, b, 8'(i)); end
    end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (tx_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL burst_drained valid=%b empty=%b want 0/1", tx_valid, empty); end
  endtask

  task automatic test_wrap;
    logic [7:0] q[$];
    logic [7:0] exp_b;
    int written = 0, received = 0, occ = 0, cyc = 0;
    logic w, p;
    while (received < 40 && cyc < 3000) begin
      w = written < 40 && occ < 15 && ($urandom_range(0, 2) != 0);
      p = tx_valid && ($urandom_range(0, 1) != 0);
      wr_valid = w;
      wr_byte  = 8'($urandom);
      tx_done  = p;
      if (w) begin q.push_back(wr_byte); written++; end
      if (p) begin
        exp_b = q.pop_front();
        checks++; if (tx_byte !== exp_b) begin errors++; $display("FAIL wrap_byte[%0d] got=%h want=%h", received, tx_byte, exp_b); end
        received++;
      end
      occ = occ + int'(w) - int'(p);
      tick();
      cyc++;
      checks++; if (count !== 5'(occ)) begin errors++; $display("FAIL wrap_count cyc=%0d got=%0d want=%0d", cyc, count, occ); end
    end
    wr_valid = 1'b0;
    tx_done  = 1'b0;
    checks++; if (received != 40) begin errors++; $display("FAIL wrap_timeout received=%0d want=40", received); end
    tick(); tick();
  endtask

  task automatic test_coincident;
    logic [7:0] b;
    logic       ok;
    logic [7:0] exp_b[3] = '{8'hB1, 8'hB2, 8'h3C};
    write1(8'hB0); write1(8'hB1); write1(8'hB2);
    for (int i = 0; i < 20 && !tx_valid; i++) tick();
    checks++; if (tx_valid !== 1'b1 || tx_byte !== 8'hB0 || count !== 5'd3) begin errors++; $display("FAIL coinc_setup valid=%b byte=%h count=%0d", tx_valid, tx_byte, count); end
    tx_done = 1'b1;
    write1(8'h3C);
    tx_done = 1'b0;
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL coinc_count got=%0d want=3", count); end
    for (int i = 0; i < 3; i++) begin
      get_byte(b, ok);
      checks++; if (!ok || b !== exp_b[i]) begin errors++; $display("FAIL coinc_order[%0d] ok=%b got=%h want=%h", i, ok, b, exp_b[i]); end
    end
    tick(); tick();
  endtask

  task automatic test_gap;
    logic [7:0] b;
    logic       ok;
    write1(8'h11); write1(8'h22);
    for (int i = 0; i < 20 && !tx_valid; i++) tick();
    tx_done = 1'b1;
    tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL gap_k valid=%b want=0", tx_valid); end
    tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL gap_k1 valid=%b want=0", tx_valid); end
    tick();
    tx_done = 1'b0;
    checks++; if (tx_valid !== 1'b1 || tx_byte !== 8'h22 || count !== 5'd1) begin errors++; $display("FAIL gap_k2 valid=%b byte=%h count=%0d want 1/22/1", tx_valid, tx_byte, count); end
    get_byte(b, ok);
    checks++; if (!ok || b !== 8'h22 || count !== 5'd0) begin errors++; $display("FAIL gap_last ok=%b byte=%h count=%0d", ok, b, count); end
    tick(); tick();
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    logic       ok;
    logic       seen = 1'b0;
    for (int i = 0; i < 5; i++) write1(8'h50 + 8'(i));
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    tick();
    checks++; if (tx_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL rstmid valid=%b count=%0d empty=%b want 0/0/1", tx_valid, count, empty); end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_quiet valid_seen=%b want=0", seen); end
    write1(8'h77);
    get_byte(b, ok);
    checks++; if (!ok || b !== 8'h77) begin errors++; $display("FAIL rstmid_new ok=%b byte=%h want 1/77", ok, b); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_wrap();
    test_coincident();
    test_gap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
